conv_operand_feeder: RTL and testbench

Serial-to-parallel operand loader for the 32-lane convolution datapath. Accepts a 4-bit nibble stream over a valid/ready handshake, assembles one 32-nibble weight vector followed by NUM_IFM 32-nibble IFM vectors per frame, and presents each completed vector on a 128-bit bus with a one-cycle strobe (`weight_valid` / `in_valid`). Sits upstream of the convolution engine: bus lane k (bits [4k+3:4k]) drives In_Weight_(k+1) / In_IFM_(k+1).

---
 rtl/conv_operand_feeder.sv | 129 ++++++++++++
 tb/tb_conv_operand_feeder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_operand_feeder.sv
`default_nettype none
// =============================================================================
// conv_operand_feeder: assembles a 4-bit nibble stream into one weight vector
// and NUM_IFM IFM vectors per frame, each presented on a 128-bit bus.
// Optional macro FEEDER_WEIGHT_SKIP_EN adds skip_w (frame reuses last weights).
// Revision: 1.0
// =============================================================================
module conv_operand_feeder #(
  parameter int LANES   = 32,
  parameter int DW      = 4,
  parameter int NUM_IFM = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef FEEDER_WEIGHT_SKIP_EN
  input  logic                skip_w,
`endif
  input  logic                s_valid,
  input  logic [DW-1:0]       s_data,
  output logic                s_ready,
  output logic                weight_valid,
  output logic [LANES*DW-1:0] weight_bus,
  output logic                in_valid,
  output logic [LANES*DW-1:0] ifm_bus,
  output logic                busy,
  output logic                done
);

  localparam int LW = $clog2(LANES);
  localparam int VW = $clog2(NUM_IFM + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [VW-1:0] LAST_VEC  = VW'(NUM_IFM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_I = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [LW-1:0]       r_lane_cnt;
  logic [VW-1:0]       r_vec_cnt;
  logic [LANES*DW-1:0] r_staging;
  logic [LANES*DW-1:0] w_vec;
  logic                w_loading;
  logic                w_beat;
  logic                w_last_lane;

  assign w_loading   = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_I);
  assign s_ready     = w_loading;
  assign busy        = w_loading;
  assign w_beat      = s_valid && w_loading;
  assign w_last_lane = (r_lane_cnt == LAST_LANE);

  // Staging image with the current beat merged in, so a completing vector can
  // be published in the same edge that accepts its last nibble.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_vec[k*DW +: DW] = (r_lane_cnt == LW'(k)) ? s_data : r_staging[k*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lane_cnt   <= '0;
      r_vec_cnt    <= '0;
      r_staging    <= '0;
      weight_bus   <= '0;
      ifm_bus      <= '0;
      weight_valid <= 1'b0;
      in_valid     <= 1'b0;
      done         <= 1'b0;
    end else begin
      weight_valid <= 1'b0;
      in_valid     <= 1'b0;
      done         <= 1'b0;

      if (w_beat) begin
        r_staging  <= w_vec;
        r_lane_cnt <= w_last_lane ? '0 : r_lane_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_lane_cnt <= '0;
            r_vec_cnt  <= '0;
`ifdef FEEDER_WEIGHT_SKIP_EN
            r_state    <= skip_w ? ST_LOAD_I : ST_LOAD_W;
`else
            r_state    <= ST_LOAD_W;
`endif
          end
        end

        ST_LOAD_W: begin
          if (w_beat && w_last_lane) begin
            weight_bus   <= w_vec;
            weight_valid <= 1'b1;
            r_state      <= ST_LOAD_I;
          end
        end

        ST_LOAD_I: begin
          if (w_beat && w_last_lane) begin
            ifm_bus   <= w_vec;
            in_valid  <= 1'b1;
            r_vec_cnt <= r_vec_cnt + 1'b1;
            if (r_vec_cnt == LAST_VEC) begin
              done    <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_operand_feeder.sv
`default_nettype none
// Bench for conv_operand_feeder: table-driven frames, hand sequences for reset
// and ignored inputs, plus random traffic against a queue-based model.
module tb_conv_operand_feeder;

  localparam int LANES = 32;
  localparam int DW    = 4;
  localparam int NIFM  = 2;
`ifdef FEEDER_WEIGHT_SKIP_EN
  localparam bit HAS_SKIP = 1'b1;
`else
  localparam bit HAS_SKIP = 1'b0;
`endif

  localparam logic [127:0] RAMP = 128'hFEDCBA98_76543210_FEDCBA98_76543210;
  localparam logic [127:0] IFM1 = {32{4'h5}};
  localparam logic [127:0] IFM2 = {32{4'hA}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         skip_w = 1'b0;
  logic         s_valid = 1'b0;
  logic [3:0]   s_data = 4'h0;
  logic         s_ready;
  logic         weight_valid;
  logic [127:0] weight_bus;
  logic         in_valid;
  logic [127:0] ifm_bus;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  conv_operand_feeder #(.LANES(LANES), .DW(DW), .NUM_IFM(NIFM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef FEEDER_WEIGHT_SKIP_EN
    .skip_w       (skip_w),
`endif
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .weight_valid (weight_valid),
    .weight_bus   (weight_bus),
    .in_valid     (in_valid),
    .ifm_bus      (ifm_bus),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 weight, 2 ifm, 3 done; nibbles collect in a queue.
  int           m_phase;
  int           m_nvec;
  logic [3:0]   m_q[$];
  logic [127:0] m_wbus, m_ibus;
  logic         m_wv, m_iv, m_done;

  task automatic model_reset();
    m_phase = 0; m_nvec = 0; m_q.delete();
    m_wbus = '0; m_ibus = '0; m_wv = 0; m_iv = 0; m_done = 0;
  endtask

  task automatic model_step();
    logic [127:0] vec;
    vec = '0;
    m_wv = 0; m_iv = 0; m_done = 0;
    case (m_phase)
      0: if (start) begin
        m_q.delete();
        m_nvec  = 0;
        m_phase = (HAS_SKIP && skip_w) ? 2 : 1;
      end
      1, 2: if (s_valid) begin
        m_q.push_back(s_data);
        if (m_q.size() == LANES) begin
          for (int i = 0; i < LANES; i++) vec[i*4 +: 4] = m_q[i];
          m_q.delete();
          if (m_phase == 1) begin
            m_wbus = vec; m_wv = 1; m_phase = 2;
          end else begin
            m_ibus = vec; m_iv = 1; m_nvec++;
            if (m_nvec == NIFM) begin m_phase = 3; m_done = 1; end
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    logic exp_ld;
    exp_ld = (m_phase == 1) || (m_phase == 2);
    chkb("s_ready", s_ready, exp_ld);
    chkb("busy", busy, exp_ld);
    chkb("weight_valid", weight_valid, m_wv);
    chkb("in_valid", in_valid, m_iv);
    chkb("done", done, m_done);
    chkv("weight_bus", weight_bus, m_wbus);
    chkv("ifm_bus", ifm_bus, m_ibus);
  endtask

  task automatic cycle(input bit st, input bit sv, input logic [3:0] sd, input bit sk, output bit acc);
    start = st; s_valid = sv; s_data = sd; skip_w = sk;
    @(posedge clk);
    acc = ((m_phase == 1) || (m_phase == 2)) && sv;
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run_frame(input logic [127:0] w, input bit stall, input bit sk, input int poke,
                           output int wlat, output int ilat1, output int ilat2, output int dlat,
                           output logic [127:0] wcap, output logic [127:0] icap1,
                           output logic [127:0] icap2);
    logic [127:0] vecs[3];
    logic [127:0] cur;
    int  nvec, idx, nin;
    bit  acc, v;
    wlat = -1; ilat1 = -1; ilat2 = -1; dlat = -1;
    wcap = '0; icap1 = '0; icap2 = '0;
    idx = 0; nin = 0;
    if (sk) begin vecs[0] = IFM1; vecs[1] = IFM2; vecs[2] = '0; nvec = 2; end
    else    begin vecs[0] = w;    vecs[1] = IFM1; vecs[2] = IFM2; nvec = 3; end
    cycle(1'b1, 1'b0, 4'h0, sk, acc);
    for (int t = 1; t <= 400; t++) begin
      v   = (idx < nvec*LANES) && (!stall || (t % 2 == 0));
      cur = vecs[(idx < nvec*LANES) ? idx / LANES : 0];
      cycle(t == poke, v, cur[(idx % LANES)*4 +: 4], 1'b0, acc);
      if (acc) idx++;
      if (weight_valid) begin wlat = t; wcap = weight_bus; end
      if (in_valid) begin
        if (nin == 0) begin ilat1 = t; icap1 = ifm_bus; end
        else          begin ilat2 = t; icap2 = ifm_bus; end
        nin++;
      end
      if (done) begin
        dlat = t;
        chkb("s_ready_at_done", s_ready, 1'b0);
        break;
      end
    end
    cycle(1'b0, 1'b1, 4'h3, 1'b0, acc);
    chkb("s_ready_after_done", s_ready, 1'b0);
    chkb("done_one_cycle", done, 1'b0);
  endtask

  typedef struct {
    logic [127:0] w_src;
    logic [127:0] w_exp;
    bit           stall;
    int           lat;
    int           poke;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int wl, il1, il2, dl;
    logic [127:0] wc, ic1, ic2;
    bit acc;

    tbl[0] = '{RAMP, 128'hFEDCBA98_76543210_FEDCBA98_76543210, 1'b0, 32, 0};
    tbl[1] = '{RAMP, 128'hFEDCBA98_76543210_FEDCBA98_76543210, 1'b1, 64, 0};
    tbl[2] = '{128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978,
               128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978, 1'b0, 32, 40};
    tbl[3] = '{128'h0000FFFF_0000FFFF_C3C3C3C3_5A5A5A5A,
               128'h0000FFFF_0000FFFF_C3C3C3C3_5A5A5A5A, 1'b1, 64, 100};
    tbl[4] = '{128'h80000000_00000000_00000000_00000001,
               128'h80000000_00000000_00000000_00000001, 1'b0, 32, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_s_ready", s_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_weight_valid", weight_valid, 1'b0);
    chkb("rst_in_valid", in_valid, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkv("rst_weight_bus", weight_bus, '0);
    chkv("rst_ifm_bus", ifm_bus, '0);
    rst_n = 1'b1;

    for (int e = 0; e < 5; e++) begin
      run_frame(tbl[e].w_src, tbl[e].stall, 1'b0, tbl[e].poke, wl, il1, il2, dl, wc, ic1, ic2);
      chki("tbl_w_lat", wl, tbl[e].lat);
      chki("tbl_i1_lat", il1, 2 * tbl[e].lat);
      chki("tbl_i2_lat", il2, 3 * tbl[e].lat);
      chki("tbl_done_lat", dl, 3 * tbl[e].lat);
      chkv("tbl_weight", wc, tbl[e].w_exp);
      chkv("tbl_ifm1", ic1, {32{4'h5}});
      chkv("tbl_ifm2", ic2, {32{4'hA}});
    end

    // s_valid while idle must not be accepted nor disturb the buses.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 4'hF, 1'b0, acc);
      chkb("idle_s_ready", s_ready, 1'b0);
      chkv("idle_weight_hold", weight_bus, 128'h80000000_00000000_00000000_00000001);
      chkv("idle_ifm_hold", ifm_bus, {32{4'hA}});
    end

    // Asynchronous reset in the middle of the first IFM vector (lane 17).
    cycle(1'b1, 1'b0, 4'h0, 1'b0, acc);
    for (int i = 0; i < LANES + 17; i++) cycle(1'b0, 1'b1, 4'($urandom), 1'b0, acc);
    start = 1'b0; s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chkb("arst_s_ready", s_ready, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    chkb("arst_in_valid", in_valid, 1'b0);
    chkb("arst_done", done, 1'b0);
    chkv("arst_weight_bus", weight_bus, '0);
    chkv("arst_ifm_bus", ifm_bus, '0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(RAMP, 1'b0, 1'b0, 0, wl, il1, il2, dl, wc, ic1, ic2);
    chki("post_rst_w_lat", wl, 32);
    chkv("post_rst_weight", wc, 128'hFEDCBA98_76543210_FEDCBA98_76543210);
    chkv("post_rst_ifm1", ic1, {32{4'h5}});

`ifdef FEEDER_WEIGHT_SKIP_EN
    run_frame(128'h0, 1'b0, 1'b1, 0, wl, il1, il2, dl, wc, ic1, ic2);
    chki("skip_no_weight_valid", wl, -1);
    chki("skip_i1_lat", il1, 32);
    chki("skip_done_lat", dl, 64);
    chkv("skip_weight_kept", weight_bus, 128'hFEDCBA98_76543210_FEDCBA98_76543210);
    chkv("skip_ifm2", ic2, {32{4'hA}});
`endif

    // Random traffic: stray starts, stalls, idle-time s_valid, optional skips.
    for (int i = 0; i < 2500; i++) begin
      cycle(($urandom % 8) == 0, ($urandom % 4) != 0, 4'($urandom), 1'($urandom), acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
